// File: rtl/uc_jogo_principal_param.sv
// Main control unit for the asteroids game. It sequences game start, move capture, shot
// registration, movement rounds and life loss, with configurable lives, shot limit and move timeout.
module uc_jogo_principal_param #(
  parameter int N_VIDAS         = 3,
  parameter int LARGURA_VIDAS   = 2,
  parameter int MAX_TIROS       = 4,
  parameter int LARGURA_TIROS   = 3,
  parameter int TIMEOUT_JOGADA  = 1000,
  parameter int LARGURA_TIMEOUT = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic                     ocorreu_jogada,
  input  logic                     ocorreu_tiro,
  input  logic                     tiro_removido,
  input  logic                     fim_movimentacao,
  input  logic                     colisao_nave,
  output logic                     enable_reg_jogada,
  output logic                     reset_reg_jogada,
  output logic                     inicia_movimentacao,
  output logic                     registra_tiro,
  output logic                     reset_contador_asteroides,
  output logic                     reset_move_tiros,
  output logic                     reset_registra_tiros,
  output logic [LARGURA_VIDAS-1:0] vidas,
  output logic [LARGURA_TIROS-1:0] tiros_ativos,
  output logic                     acabou_vidas,
  output logic                     pronto,
  output logic [4:0]               db_estado
);

  typedef enum logic [4:0] {
    INICIAL              = 5'b00000,
    INICIALIZA_ELEMENTOS = 5'b00001,
    ESPERA_JOGADA        = 5'b00010,
    REGISTRA_JOGADA      = 5'b00011,
    REGISTRA_TIRO        = 5'b00100,
    INICIA_MOVIMENTO     = 5'b00101,
    AGUARDA_MOVIMENTO    = 5'b00110,
    PERDE_VIDA           = 5'b00111,
    FIM_JOGO             = 5'b01000
  } estado_t;

  localparam logic [LARGURA_VIDAS-1:0]   VIDAS_INI   = LARGURA_VIDAS'(N_VIDAS);
  localparam logic [LARGURA_TIROS-1:0]   TIROS_LIM   = LARGURA_TIROS'(MAX_TIROS);
  localparam logic [LARGURA_TIMEOUT-1:0] TIMEOUT_LIM = LARGURA_TIMEOUT'(TIMEOUT_JOGADA - 1);
  localparam logic                       TIMEOUT_ON  = (TIMEOUT_JOGADA != 0);
  localparam logic [4:0]                 DB_ILEGAL   = 5'b01101;

  estado_t                    estado_q, estado_d;
  logic [LARGURA_VIDAS-1:0]   vidas_q, vidas_d;
  logic [LARGURA_TIROS-1:0]   tiros_q, tiros_d;
  logic [LARGURA_TIMEOUT-1:0] timer_q, timer_d;
  logic                       inc_tiro_s, dec_tiro_s;

  logic enable_reg_jogada_q, reset_reg_jogada_q, inicia_movimentacao_q, registra_tiro_q;
  logic reset_contador_asteroides_q, reset_move_tiros_q, reset_registra_tiros_q;
  logic acabou_vidas_q, pronto_q;
  logic [4:0] db_estado_q;

  // Debug code for a state; anything outside the enumerated set reports as illegal.
  function automatic logic [4:0] codigo_debug(input estado_t e);
    logic [4:0] c;
    case (e)
      INICIAL, INICIALIZA_ELEMENTOS, ESPERA_JOGADA, REGISTRA_JOGADA, REGISTRA_TIRO,
      INICIA_MOVIMENTO, AGUARDA_MOVIMENTO, PERDE_VIDA, FIM_JOGO: c = e;
      default: c = DB_ILEGAL;
    endcase
    return c;
  endfunction

  // Next-state logic.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = INICIALIZA_ELEMENTOS;
        else         estado_d = INICIAL;
      end
      INICIALIZA_ELEMENTOS: estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (ocorreu_jogada)                           estado_d = REGISTRA_JOGADA;
        else if (TIMEOUT_ON && timer_q == TIMEOUT_LIM) estado_d = INICIA_MOVIMENTO;
        else                                          estado_d = ESPERA_JOGADA;
      end
      REGISTRA_JOGADA: begin
        // A shot arriving with the shot table full is dropped; the move still runs.
        if (ocorreu_tiro && tiros_q < TIROS_LIM) estado_d = REGISTRA_TIRO;
        else                                     estado_d = INICIA_MOVIMENTO;
      end
      REGISTRA_TIRO:    estado_d = INICIA_MOVIMENTO;
      INICIA_MOVIMENTO: estado_d = AGUARDA_MOVIMENTO;
      AGUARDA_MOVIMENTO: begin
        if (fim_movimentacao && colisao_nave) estado_d = PERDE_VIDA;
        else if (fim_movimentacao)            estado_d = ESPERA_JOGADA;
        else                                  estado_d = AGUARDA_MOVIMENTO;
      end
      PERDE_VIDA: begin
        if (vidas_q == LARGURA_VIDAS'(1)) estado_d = FIM_JOGO;
        else                              estado_d = ESPERA_JOGADA;
      end
      FIM_JOGO: begin
        if (iniciar) estado_d = INICIALIZA_ELEMENTOS;
        else         estado_d = FIM_JOGO;
      end
      default: estado_d = INICIAL;
    endcase
  end

  // Lives, active-shot count and move timer next values.
  always_comb begin
    inc_tiro_s = (estado_q == REGISTRA_TIRO);
    dec_tiro_s = tiro_removido;
    vidas_d    = vidas_q;
    tiros_d    = tiros_q;
    timer_d    = '0;

    if (estado_q == INICIALIZA_ELEMENTOS) begin
      vidas_d = VIDAS_INI;
    end else if (estado_q == PERDE_VIDA && vidas_q != '0) begin
      vidas_d = vidas_q - LARGURA_VIDAS'(1);
    end else begin
      vidas_d = vidas_q;
    end

    // A removal coinciding with a spawn cancels out; removals saturate at zero.
    if (estado_q == INICIALIZA_ELEMENTOS) begin
      tiros_d = '0;
    end else if (inc_tiro_s && !dec_tiro_s) begin
      tiros_d = tiros_q + LARGURA_TIROS'(1);
    end else if (dec_tiro_s && !inc_tiro_s && tiros_q != '0) begin
      tiros_d = tiros_q - LARGURA_TIROS'(1);
    end else begin
      tiros_d = tiros_q;
    end

    if (estado_q == ESPERA_JOGADA) timer_d = timer_q + LARGURA_TIMEOUT'(1);
    else                           timer_d = '0;
  end

  // State, counters and Moore outputs decoded from the upcoming state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q                    <= INICIAL;
      vidas_q                     <= VIDAS_INI;
      tiros_q                     <= '0;
      timer_q                     <= '0;
      enable_reg_jogada_q         <= 1'b0;
      reset_reg_jogada_q          <= 1'b0;
      inicia_movimentacao_q       <= 1'b0;
      registra_tiro_q             <= 1'b0;
      reset_contador_asteroides_q <= 1'b0;
      reset_move_tiros_q          <= 1'b0;
      reset_registra_tiros_q      <= 1'b0;
      acabou_vidas_q              <= 1'b0;
      pronto_q                    <= 1'b0;
      db_estado_q                 <= 5'b00000;
    end else begin
      estado_q                    <= estado_d;
      vidas_q                     <= vidas_d;
      tiros_q                     <= tiros_d;
      timer_q                     <= timer_d;
      enable_reg_jogada_q         <= (estado_d == REGISTRA_JOGADA);
      reset_reg_jogada_q          <= (estado_d == INICIALIZA_ELEMENTOS);
      inicia_movimentacao_q       <= (estado_d == INICIA_MOVIMENTO);
      registra_tiro_q             <= (estado_d == REGISTRA_TIRO);
      reset_contador_asteroides_q <= (estado_d == INICIALIZA_ELEMENTOS);
      reset_move_tiros_q          <= (estado_d == INICIALIZA_ELEMENTOS);
      reset_registra_tiros_q      <= (estado_d == INICIALIZA_ELEMENTOS);
      acabou_vidas_q              <= (estado_d == FIM_JOGO);
      pronto_q                    <= (estado_d == FIM_JOGO);
      db_estado_q                 <= codigo_debug(estado_d);
    end
  end

  assign enable_reg_jogada         = enable_reg_jogada_q;
  assign reset_reg_jogada          = reset_reg_jogada_q;
  assign inicia_movimentacao       = inicia_movimentacao_q;
  assign registra_tiro             = registra_tiro_q;
  assign reset_contador_asteroides = reset_contador_asteroides_q;
  assign reset_move_tiros          = reset_move_tiros_q;
  assign reset_registra_tiros      = reset_registra_tiros_q;
  assign vidas                     = vidas_q;
  assign tiros_ativos              = tiros_q;
  assign acabou_vidas              = acabou_vidas_q;
  assign pronto                    = pronto_q;
  assign db_estado                 = db_estado_q;

endmodule

// File: tb/tb_uc_jogo_principal_param.sv
// Directed bench for uc_jogo_principal_param: start, shots up to the limit, move timeout,
// life loss to game over, restart, coincident shot spawn/removal and asynchronous reset.
module tb_uc_jogo_principal_param;

  logic       clock = 1'b0;
  logic       reset, iniciar, ocorreu_jogada, ocorreu_tiro, tiro_removido;
  logic       fim_movimentacao, colisao_nave;
  logic       enable_reg_jogada, reset_reg_jogada, inicia_movimentacao, registra_tiro;
  logic       reset_contador_asteroides, reset_move_tiros, reset_registra_tiros;
  logic [1:0] vidas;
  logic [2:0] tiros_ativos;
  logic       acabou_vidas, pronto;
  logic [4:0] db_estado;

  int checks   = 0;
  int failures = 0;
  int pulses, lat, n;

  uc_jogo_principal_param #(
    .N_VIDAS(3), .LARGURA_VIDAS(2), .MAX_TIROS(4), .LARGURA_TIROS(3),
    .TIMEOUT_JOGADA(8), .LARGURA_TIMEOUT(10)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .ocorreu_jogada(ocorreu_jogada),
    .ocorreu_tiro(ocorreu_tiro), .tiro_removido(tiro_removido),
    .fim_movimentacao(fim_movimentacao), .colisao_nave(colisao_nave),
    .enable_reg_jogada(enable_reg_jogada), .reset_reg_jogada(reset_reg_jogada),
    .inicia_movimentacao(inicia_movimentacao), .registra_tiro(registra_tiro),
    .reset_contador_asteroides(reset_contador_asteroides), .reset_move_tiros(reset_move_tiros),
    .reset_registra_tiros(reset_registra_tiros), .vidas(vidas), .tiros_ativos(tiros_ativos),
    .acabou_vidas(acabou_vidas), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One player move from espera_jogada; returns shot pulses seen and move-to-start latency.
  task automatic rodada(input logic tiro, input logic col, output int np, output int nl);
    np = 0;
    nl = 0;
    ocorreu_jogada = 1'b1;
    ocorreu_tiro   = tiro;
    tick();
    nl = 1;
    ocorreu_jogada = 1'b0;
    while (!inicia_movimentacao && nl < 6) begin
      if (registra_tiro) np++;
      tick();
      nl++;
    end
    ocorreu_tiro = 1'b0;
    tick();
    chk("inicia_one_cycle", {31'b0, inicia_movimentacao}, 32'd0);
    chk("aguarda_state", {27'b0, db_estado}, 32'd6);
    fim_movimentacao = 1'b1;
    colisao_nave     = col;
    tick();
    fim_movimentacao = 1'b0;
    colisao_nave     = 1'b0;
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; ocorreu_jogada = 1'b0; ocorreu_tiro = 1'b0;
    tiro_removido = 1'b0; fim_movimentacao = 1'b0; colisao_nave = 1'b0;
    tick(); tick();
    chk("rst_state", {27'b0, db_estado}, 32'd0);
    chk("rst_vidas", {30'b0, vidas}, 32'd3);
    chk("rst_tiros", {29'b0, tiros_ativos}, 32'd0);
    chk("rst_pronto", {31'b0, pronto}, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_state", {27'b0, db_estado}, 32'd0);

    // Start: inicial -> inicializa_elementos -> espera_jogada
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("init_state", {27'b0, db_estado}, 32'd1);
    chk("init_resets", {28'b0, reset_reg_jogada, reset_contador_asteroides,
                        reset_move_tiros, reset_registra_tiros}, 32'hF);
    tick();
    chk("espera_state", {27'b0, db_estado}, 32'd2);
    chk("start_vidas", {30'b0, vidas}, 32'd3);
    chk("start_tiros", {29'b0, tiros_ativos}, 32'd0);

    // iniciar has no effect while waiting for a move
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("iniciar_ignored", {27'b0, db_estado}, 32'd2);

    // Shot move with a detailed walk through the states
    ocorreu_jogada = 1'b1; ocorreu_tiro = 1'b1;
    tick();
    ocorreu_jogada = 1'b0;
    chk("reg_jogada_state", {27'b0, db_estado}, 32'd3);
    chk("enable_reg", {31'b0, enable_reg_jogada}, 32'd1);
    tick();
    ocorreu_tiro = 1'b0;
    chk("reg_tiro_state", {27'b0, db_estado}, 32'd4);
    chk("reg_tiro_pulse", {31'b0, registra_tiro}, 32'd1);
    tick();
    chk("ini_mov_state", {27'b0, db_estado}, 32'd5);
    chk("ini_mov_pulse", {31'b0, inicia_movimentacao}, 32'd1);
    chk("reg_tiro_drop", {31'b0, registra_tiro}, 32'd0);
    chk("tiros_after_1", {29'b0, tiros_ativos}, 32'd1);
    tick();
    chk("ini_mov_low", {31'b0, inicia_movimentacao}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("aguarda_hold", {27'b0, db_estado}, 32'd6);
    fim_movimentacao = 1'b1;
    tick();
    fim_movimentacao = 1'b0;
    chk("back_espera", {27'b0, db_estado}, 32'd2);

    // Shots up to the limit of 4; later shots dropped
    for (int k = 0; k < 5; k++) begin
      rodada(1'b1, 1'b0, pulses, lat);
      chk("shot_pulses", pulses, (k < 3) ? 32'd1 : 32'd0);
      chk("shot_latency", lat, (k < 3) ? 32'd3 : 32'd2);
      chk("shot_count", {29'b0, tiros_ativos}, (k < 3) ? 32'(k + 2) : 32'd4);
    end

    // Move timeout: 8 cycles after entering espera_jogada
    n = 0;
    while (!inicia_movimentacao && n < 20) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 32'd8);
    tick();
    chk("timeout_aguarda", {27'b0, db_estado}, 32'd6);
    tiro_removido = 1'b1;
    tick(); tick();
    tiro_removido = 1'b0;
    chk("removido_x2", {29'b0, tiros_ativos}, 32'd2);
    fim_movimentacao = 1'b1;
    tick();
    fim_movimentacao = 1'b0;

    // Removal coincident with spawn at 2 shots keeps count at 2
    ocorreu_jogada = 1'b1; ocorreu_tiro = 1'b1;
    tick();
    ocorreu_jogada = 1'b0;
    tick();
    ocorreu_tiro = 1'b0;
    chk("coinc_reg_tiro", {31'b0, registra_tiro}, 32'd1);
    tiro_removido = 1'b1;
    tick();
    tiro_removido = 1'b0;
    chk("coinc_count", {29'b0, tiros_ativos}, 32'd2);
    tick();
    fim_movimentacao = 1'b1;
    tick();
    fim_movimentacao = 1'b0;
    chk("coinc_espera", {27'b0, db_estado}, 32'd2);

    // Three collisions: 3 -> 2 -> 1 -> 0 and game over
    for (int k = 0; k < 3; k++) begin
      rodada(1'b0, 1'b1, pulses, lat);
      chk("perde_state", {27'b0, db_estado}, 32'd7);
      tick();
      chk("vidas_left", {30'b0, vidas}, 32'(2 - k));
      chk("after_loss_state", {27'b0, db_estado}, (k < 2) ? 32'd2 : 32'd8);
    end
    tick();
    chk("fim_hold", {27'b0, db_estado}, 32'd8);
    chk("fim_flags", {30'b0, pronto, acabou_vidas}, 32'd3);

    // Restart from game over
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("restart_init", {27'b0, db_estado}, 32'd1);
    tick();
    chk("restart_vidas", {30'b0, vidas}, 32'd3);
    chk("restart_tiros", {29'b0, tiros_ativos}, 32'd0);
    chk("restart_flags", {30'b0, pronto, acabou_vidas}, 32'd0);
    tiro_removido = 1'b1;
    tick();
    tiro_removido = 1'b0;
    chk("tiros_saturate", {29'b0, tiros_ativos}, 32'd0);

    // Asynchronous reset while waiting for the movement unit
    ocorreu_jogada = 1'b1;
    tick();
    ocorreu_jogada = 1'b0;
    tick(); tick();
    chk("pre_reset_state", {27'b0, db_estado}, 32'd6);
    #2 reset = 1'b0;
    #1;
    chk("async_state", {27'b0, db_estado}, 32'd0);
    chk("async_outs", {23'b0, enable_reg_jogada, reset_reg_jogada, inicia_movimentacao,
                       registra_tiro, reset_contador_asteroides, reset_move_tiros,
                       reset_registra_tiros, acabou_vidas, pronto}, 32'd0);
    chk("async_vidas", {30'b0, vidas}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
